// File: rtl/nf10_packet_encoder.sv
// nf10_packet_encoder: prepends one 32-byte encapsulation header beat per packet; PKT_ENCODER_STATS_EN adds pkt_cnt.
// Latency: header 1 cycle after first beat, payload 0 cycles; backpressure: m_axis_tready feeds s_axis_tready directly.
module nf10_packet_encoder #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_SEQ_WIDTH        = 16
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic                            encap_en,
    input  logic [31:0]                     hdr_tag,
    output logic [C_SEQ_WIDTH-1:0]          seq_num,
    output logic [31:0]                     pkt_cnt
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, BYPASS} state_t;

    state_t                          state_q, state_d;
    logic [C_AXIS_TUSER_WIDTH-1:0]   hdr_user_q;
    logic [C_AXIS_TUSER_WIDTH-1:0]   adj_user;
    logic [31:0]                     tag_q;
    logic [C_SEQ_WIDTH-1:0]          seq_q;
    logic [15:0]                     seq_ext;
    logic [C_AXIS_DATA_WIDTH-1:0]    hdr_dat;
    logic                            hdr_fire;

    assign hdr_fire = (state_q == HDR) && m_axis_tready;
    assign seq_num  = seq_q;
    assign seq_ext  = 16'(seq_q);
    assign hdr_dat  = {hdr_user_q, tag_q, seq_ext, hdr_user_q[15:0], 64'd0};

    // Header and payload beats advertise the length including the 32-byte header
    always_comb begin
        adj_user       = hdr_user_q;
        adj_user[15:0] = hdr_user_q[15:0] + 16'd32;
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q    <= IDLE;
            hdr_user_q <= '0;
            tag_q      <= '0;
            seq_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && s_axis_tvalid) begin
                hdr_user_q <= s_axis_tuser;
                tag_q      <= hdr_tag;
            end
            if (hdr_fire) begin
                seq_q <= seq_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_d = encap_en ? HDR : BYPASS;
                end
            end
            HDR: begin
                // First input beat stays parked upstream until the header is taken
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_dat;
                m_axis_tstrb  = '1;
                m_axis_tuser  = adj_user;
                if (m_axis_tready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tstrb  = s_axis_tstrb;
                m_axis_tuser  = adj_user;
                m_axis_tlast  = s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            BYPASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tstrb  = s_axis_tstrb;
                m_axis_tuser  = s_axis_tuser;
                m_axis_tlast  = s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PKT_ENCODER_STATS_EN
    logic [31:0] pkt_cnt_q;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pkt_cnt_q <= '0;
        end else if (hdr_fire) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_nf10_packet_encoder.sv
// Directed bench for nf10_packet_encoder; a 4-bit-sequence instance runs in lockstep to reach counter wrap quickly.
module tb_nf10_packet_encoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid, s_tready, s_tlast;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid, m_tready, m_tlast;
    logic         encap_en;
    logic [31:0]  hdr_tag;
    logic [15:0]  seq_num;
    logic [31:0]  pkt_cnt;

    logic [255:0] sm_dat;
    logic [31:0]  sm_strb;
    logic [127:0] sm_user;
    logic         sm_vld, sm_last, sm_s_rdy;
    logic [3:0]   sm_seq;
    logic [31:0]  sm_pkt;

    int           checks = 0;
    int           errors = 0;
    logic [15:0]  exp_seq;
    int           exp_pkt;

    logic [255:0] q_dat[$];
    logic [31:0]  q_strb[$];
    logic [127:0] q_user[$];
    logic         q_last[$];
    logic [255:0] q_small[$];
    logic [255:0] e_dat[$];
    logic [31:0]  e_strb[$];
    logic [127:0] e_user[$];
    logic         e_last[$];

    always #5 clk = ~clk;

    nf10_packet_encoder dut (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .encap_en(encap_en), .hdr_tag(hdr_tag), .seq_num(seq_num), .pkt_cnt(pkt_cnt)
    );

    nf10_packet_encoder #(.C_SEQ_WIDTH(4)) dut_small (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(sm_s_rdy), .s_axis_tlast(s_tlast),
        .m_axis_tdata(sm_dat), .m_axis_tstrb(sm_strb), .m_axis_tuser(sm_user),
        .m_axis_tvalid(sm_vld), .m_axis_tready(m_tready), .m_axis_tlast(sm_last),
        .encap_en(encap_en), .hdr_tag(hdr_tag), .seq_num(sm_seq), .pkt_cnt(sm_pkt)
    );

    // Output beats are recorded on the falling edge, where handshake terms are settled
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            q_dat.push_back(m_tdata);
            q_strb.push_back(m_tstrb);
            q_user.push_back(m_tuser);
            q_last.push_back(m_tlast);
        end
        if (sm_vld && m_tready) begin
            q_small.push_back(sm_dat);
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat_dat(input int pid, input int b);
        return {8{pid[15:0], b[15:0]}};
    endfunction

    task automatic clear_queues();
        q_dat.delete(); q_strb.delete(); q_user.delete(); q_last.delete(); q_small.delete();
        e_dat.delete(); e_strb.delete(); e_user.delete(); e_last.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_seq = '0; exp_pkt = 0;
        clear_queues();
    endtask

    task automatic send_pkt(input bit enc, input int n, input logic [127:0] user,
                            input logic [31:0] tag, input int pid);
        logic [127:0] adj;
        int g;
        adj = user;
        adj[15:0] = user[15:0] + 16'd32;
        if (enc) begin
            e_dat.push_back({user, tag, exp_seq, user[15:0], 64'd0});
            e_strb.push_back(32'hFFFF_FFFF);
            e_user.push_back(adj);
            e_last.push_back(1'b0);
            exp_seq++;
            exp_pkt++;
        end
        @(posedge clk); #1;
        encap_en = enc;
        hdr_tag  = tag;
        for (int b = 0; b < n; b++) begin
            s_tdata  = beat_dat(pid, b);
            s_tstrb  = (b == n - 1) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
            s_tuser  = user;
            s_tlast  = (b == n - 1);
            s_tvalid = 1'b1;
            e_dat.push_back(s_tdata);
            e_strb.push_back(s_tstrb);
            e_user.push_back(enc ? adj : user);
            e_last.push_back(b == n - 1);
            g = 0;
            @(negedge clk);
            if (b == 0) begin
                chk("idle_vld", 256'(m_tvalid), 256'(0));
                chk("idle_rdy", 256'(s_tready), 256'(0));
                @(negedge clk);
            end
            while (!s_tready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (!s_tready) begin
                chk("handshake_timeout", 256'(0), 256'(1));
                break;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic compare_out(input string tag);
        chk({tag, "_beats"}, 256'(q_dat.size()), 256'(e_dat.size()));
        for (int i = 0; i < q_dat.size() && i < e_dat.size(); i++) begin
            chk({tag, "_dat"},  q_dat[i],         e_dat[i]);
            chk({tag, "_strb"}, 256'(q_strb[i]),  256'(e_strb[i]));
            chk({tag, "_user"}, 256'(q_user[i]),  256'(e_user[i]));
            chk({tag, "_last"}, 256'(q_last[i]),  256'(e_last[i]));
        end
        clear_queues();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] h;
        logic [127:0] u;
        logic [127:0] u1, u2;
        int           nsmall;

        u1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_0060;
        u2 = 128'hFEDC_BA98_7654_3210_0000_1111_2222_0100;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
        m_tready = 1'b1; encap_en = 1'b0; hdr_tag = '0;
        exp_seq = '0; exp_pkt = 0;
        #23;
        chk("rst_mvld",  256'(m_tvalid), 256'(0));
        chk("rst_srdy",  256'(s_tready), 256'(0));
        chk("rst_mdat",  m_tdata,         256'(0));
        chk("rst_mstrb", 256'(m_tstrb),   256'(0));
        chk("rst_muser", 256'(m_tuser),   256'(0));
        chk("rst_mlast", 256'(m_tlast),   256'(0));
        chk("rst_seq",   256'(seq_num),   256'(0));
        chk("rst_pkt",   256'(pkt_cnt),   256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 3-beat encapsulated packet
        send_pkt(1'b1, 3, u1, 32'hDEAD_BEEF, 1);
        chk("t1_beats", 256'(q_dat.size()), 256'(4));
        if (q_dat.size() == 4) begin
            h = q_dat[0];
            chk("t1_hdr_tag",  256'(h[127:96]),  256'(32'hDEAD_BEEF));
            chk("t1_hdr_seq",  256'(h[95:80]),   256'(16'h0000));
            chk("t1_hdr_len",  256'(h[79:64]),   256'(16'h0060));
            chk("t1_hdr_user", 256'(h[255:128]), 256'(u1));
            chk("t1_hdr_low",  256'(h[63:0]),    256'(0));
            chk("t1_hdr_strb", 256'(q_strb[0]),  256'(32'hFFFF_FFFF));
            chk("t1_pay0",     q_dat[1],         beat_dat(1, 0));
            for (int i = 0; i < 4; i++) begin
                u = q_user[i];
                chk("t1_user_len", 256'(u[15:0]),   256'(16'h0080));
                chk("t1_last",     256'(q_last[i]), 256'(i == 3));
            end
        end
        compare_out("t1");
        chk("t1_seq", 256'(seq_num), 256'(16'd1));

        // Header held under backpressure
        m_tready = 1'b0;
        fork
            send_pkt(1'b1, 2, u2, 32'h1234_5678, 2);
            begin
                int g;
                g = 0;
                @(negedge clk);
                while (!m_tvalid && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                for (int i = 0; i < 5; i++) begin
                    chk("t2_stall_vld", 256'(m_tvalid), 256'(1));
                    chk("t2_stall_hdr", m_tdata, {u2, 32'h1234_5678, 16'h0001, 16'h0100, 64'd0});
                    chk("t2_stall_rdy", 256'(s_tready), 256'(0));
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                m_tready = 1'b1;
            end
        join
        compare_out("t2");
        chk("t2_seq", 256'(seq_num), 256'(16'd2));

        // Bypass leaves everything untouched
        send_pkt(1'b0, 2, 128'h0000_0000_0000_0000_AAAA_BBBB_CCCC_0040, 32'hCAFE_F00D, 3);
        compare_out("t3");
        chk("t3_seq", 256'(seq_num), 256'(16'd2));
`ifdef PKT_ENCODER_STATS_EN
        chk("t3_pkt", 256'(pkt_cnt), 256'(32'd2));
`else
        chk("t3_pkt", 256'(pkt_cnt), 256'(32'd0));
`endif

        // Reset during the second payload beat of a 4-beat packet
        @(posedge clk); #1;
        encap_en = 1'b1; hdr_tag = 32'hA5A5_0004; s_tuser = u1;
        s_tdata = beat_dat(4, 0); s_tstrb = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_tdata = beat_dat(4, 1);
        @(negedge clk);
        chk("t4_pre_vld", 256'(m_tvalid), 256'(1));
        chk("t4_pre_dat", m_tdata, beat_dat(4, 1));
        rst_n = 1'b0;
        #1;
        chk("t4_rst_vld",  256'(m_tvalid), 256'(0));
        chk("t4_rst_dat",  m_tdata,        256'(0));
        chk("t4_rst_strb", 256'(m_tstrb),  256'(0));
        chk("t4_rst_user", 256'(m_tuser),  256'(0));
        chk("t4_rst_rdy",  256'(s_tready), 256'(0));
        chk("t4_rst_seq",  256'(seq_num),  256'(0));
        s_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_seq = '0; exp_pkt = 0;
        clear_queues();
        send_pkt(1'b1, 1, u2, 32'h0BAD_F00D, 5);
        chk("t4_post_hdr_seq", (q_dat.size() > 0) ? 256'(q_dat[0][95:80]) : 256'hDEAD, 256'(0));
        compare_out("t4");
        chk("t4_post_seq", 256'(seq_num), 256'(16'd1));

        // 10 encapsulated plus 3 bypassed packets after a fresh reset
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send_pkt(!(i == 3 || i == 7 || i == 11), 1 + (i % 3),
                     {96'h0, 16'(i), 16'h0010 + 16'(i)}, 32'h5000_0000 + 32'(i), 10 + i);
        end
        compare_out("t5");
        chk("t5_seq", 256'(seq_num), 256'(16'd10));
`ifdef PKT_ENCODER_STATS_EN
        chk("t5_pkt", 256'(pkt_cnt), 256'(32'd10));
`else
        chk("t5_pkt", 256'(pkt_cnt), 256'(32'd0));
`endif

        // Sequence wrap on the narrow instance: 10 headers so far, 5 more reach 0xF
        nsmall = 5;
        for (int i = 0; i < nsmall; i++) begin
            send_pkt(1'b1, 1, 128'h20, 32'h7000_0000, 30 + i);
        end
        chk("t6_small_pre", 256'(sm_seq), 256'(4'hF));
        clear_queues();
        send_pkt(1'b1, 1, 128'h20, 32'h7777_0000, 40);
        chk("t6_small_beats", 256'(q_small.size()), 256'(2));
        h = (q_small.size() > 0) ? q_small[0] : '1;
        chk("t6_small_hdr_seq", 256'(h[95:80]), 256'(16'h000F));
        chk("t6_small_post",    256'(sm_seq),   256'(4'h0));
        compare_out("t6");
        chk("t6_main_seq", 256'(seq_num), 256'(16'h0010));

        @(negedge clk);
        chk("end_small_vld",  256'(sm_vld),   256'(0));
        chk("end_small_rdy",  256'(sm_s_rdy), 256'(0));
        chk("end_small_last", 256'(sm_last),  256'(0));
        chk("end_small_strb", 256'(sm_strb),  256'(0));
        chk("end_small_user", 256'(sm_user),  256'(0));
`ifdef PKT_ENCODER_STATS_EN
        chk("end_small_pkt", 256'(sm_pkt), 256'(32'd16));
`else
        chk("end_small_pkt", 256'(sm_pkt), 256'(32'd0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
